// File: rtl/divmod_unit.sv
// -----------------------------------------------------------------------------
// divmod_unit
//
// Sequential restoring divider returning quotient and remainder together.
// It handles unsigned and two's-complement signed operands. It performs one
// restoring iteration per clock, so a normal divide takes WIDTH+1 cycles and
// a divide by zero takes one cycle.
//
// Ports:
//   clock        in   single clock, all state changes on posedge
//   reset        in   synchronous active-high reset
//   start        in   request; only sampled while busy=0
//   signed_mode  in   1 = two's-complement operands, 0 = unsigned
//   dividend     in   [WIDTH-1:0] sampled with start
//   divisor      in   [WIDTH-1:0] sampled with start
//   busy         out  high while an operation is in flight
//   done         out  one-cycle pulse, results valid in that cycle
//   quotient     out  [WIDTH-1:0] held until the next completed operation
//   remainder    out  [WIDTH-1:0] held until the next completed operation
//   div_zero     out  set with done when divisor was zero, held with results
// -----------------------------------------------------------------------------
module divmod_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;        // partial remainder
    logic [WIDTH-1:0] q_q;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] m_q;        // divisor magnitude
    logic [WIDTH-1:0] dvd_q;      // original dividend, returned on divide by zero
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             zero_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] rem_d;

    always_comb begin
        // Negating MIN yields MIN, which read as unsigned is exactly 2^(WIDTH-1).
        dvd_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

        // The shifted partial remainder needs WIDTH+1 bits: it can reach 2*M-1.
        // Since a_sh < 2*M, T stays within [-2^WIDTH, 2^WIDTH) and its top bit
        // is a reliable sign.
        a_sh = {a_q, q_q[WIDTH-1]};
        t    = a_sh - {1'b0, m_q};
        a_d  = t[WIDTH] ? a_sh[WIDTH-1:0] : t[WIDTH-1:0];
        q_d  = {q_q[WIDTH-2:0], ~t[WIDTH]};

        quot_d = quo_neg_q ? -q_q : q_q;
        rem_d  = rem_neg_q ? -a_q : a_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            dvd_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        quo_neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rem_neg_q <= signed_mode & dividend[WIDTH-1];
                        dvd_q     <= dividend;
                        m_q       <= dvs_mag;
                        a_q       <= '0;
                        q_q       <= dvd_mag;
                        cnt_q     <= CW'(WIDTH);
                        zero_q    <= (divisor == '0);
                        busy      <= 1'b1;
                        state_q   <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (zero_q) begin
                        quotient  <= '1;
                        remainder <= dvd_q;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= quot_d;
                        remainder <= rem_d;
                        div_zero  <= 1'b0;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_unit.sv
// -----------------------------------------------------------------------------
// tb_divmod_unit
//
// Self-checking bench for divmod_unit. It uses three instances (WIDTH 32, 8
// and 16). Expected results come from a behavioural model or from constants.
// They are queued when an operation is launched and popped when its done
// pulse arrives.
// -----------------------------------------------------------------------------
module tb_divmod_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0 -> WIDTH 32, 1 -> WIDTH 8, 2 -> WIDTH 16
    int unsigned W [3] = '{32, 8, 16};

    logic        st [3];
    logic        sm [3];
    logic [31:0] dv [3];
    logic [31:0] ds [3];
    logic        bz [3];
    logic        dn [3];
    logic        dz [3];
    logic [31:0] qo [3];
    logic [31:0] ro [3];

    logic [31:0] q32, r32;
    logic [7:0]  q8,  r8;
    logic [15:0] q16, r16;

    always_comb begin
        qo[0] = q32;
        ro[0] = r32;
        qo[1] = {24'h0, q8};
        ro[1] = {24'h0, r8};
        qo[2] = {16'h0, q16};
        ro[2] = {16'h0, r16};
    end

    divmod_unit #(.WIDTH(32)) u_w32 (
        .clock(clk), .reset(rst), .start(st[0]), .signed_mode(sm[0]),
        .dividend(dv[0]), .divisor(ds[0]), .busy(bz[0]), .done(dn[0]),
        .quotient(q32), .remainder(r32), .div_zero(dz[0])
    );

    divmod_unit #(.WIDTH(8)) u_w8 (
        .clock(clk), .reset(rst), .start(st[1]), .signed_mode(sm[1]),
        .dividend(dv[1][7:0]), .divisor(ds[1][7:0]), .busy(bz[1]), .done(dn[1]),
        .quotient(q8), .remainder(r8), .div_zero(dz[1])
    );

    divmod_unit #(.WIDTH(16)) u_w16 (
        .clock(clk), .reset(rst), .start(st[2]), .signed_mode(sm[2]),
        .dividend(dv[2][15:0]), .divisor(ds[2][15:0]), .busy(bz[2]), .done(dn[2]),
        .quotient(q16), .remainder(r16), .div_zero(dz[2])
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] msk(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    // Reference model: native 64-bit division, which truncates toward zero.
    function automatic exp_t model(input int unsigned w, input logic [31:0] a_in,
                                   input logic [31:0] b_in, input logic s);
        exp_t        e;
        logic [31:0] m, a, b;
        longint      sa, sb;
        m = msk(w);
        a = a_in & m;
        b = b_in & m;
        e.lat = (b == 32'h0) ? 1 : int'(w) + 1;
        if (b == 32'h0) begin
            e.q = m;
            e.r = a;
            e.z = 1'b1;
            return e;
        end
        e.z = 1'b0;
        if (s) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
            e.q = 32'(sa / sb) & m;
            e.r = 32'(sa % sb) & m;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Driver: launch one operation (caller is between edges) and wait for done.
    task automatic go(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                      output logic [31:0] q, output logic [31:0] r, output logic z,
                      output int lat);
        dv[i] = a & msk(W[i]);
        ds[i] = b & msk(W[i]);
        sm[i] = s;
        st[i] = 1'b1;
        @(posedge clk); #1;
        st[i] = 1'b0;
        lat = 0;
        while (dn[i] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = qo[i];
        r = ro[i];
        z = dz[i];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; sm[i] = 1'b0; dv[i] = '0; ds[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({bz[i], dn[i], dz[i], qo[i], ro[i]} !== 67'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
                         i, bz[i], dn[i], dz[i], qo[i], ro[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        int   lat;
        logic busy_bad;
        exp_t e;
        sbq.push_back('{q: 32'd14, r: 32'd2, z: 1'b0, lat: 33});
        dv[0] = 32'd100; ds[0] = 32'd7; sm[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        while (dn[0] !== 1'b1 && lat < 100) begin
            if (bz[0] !== 1'b1) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        e = sbq.pop_front();
        n_chk++;
        if ({qo[0], ro[0], dz[0], lat} !== {e.q, e.r, e.z, e.lat}) begin
            n_fail++;
            $display("FAIL unsigned_basic: q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d dz=%b lat=%0d",
                     qo[0], ro[0], dz[0], lat, e.q, e.r, e.z, e.lat);
        end
        n_chk++;
        if (busy_bad !== 1'b0 || bz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_window: busy dropped early=%b busy at done=%b, required 0/0",
                     busy_bad, bz[0]);
        end
        @(posedge clk); #1;
        n_chk++;
        if (dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b one cycle after done, required 0", dn[0]);
        end
    endtask

    task automatic test_signed_w8();
        logic [31:0] va [4] = '{32'hF9, 32'h07, 32'h80, 32'hFF};
        logic [31:0] vb [4] = '{32'h02, 32'hFE, 32'hFF, 32'h10};
        logic        vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eq [4] = '{32'hFD, 32'hFD, 32'h80, 32'h0F};
        logic [31:0] er [4] = '{32'hFF, 32'h01, 32'h00, 32'h0F};
        logic [31:0] q, r;
        logic        z;
        int          lat;
        exp_t        e;
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{q: eq[k], r: er[k], z: 1'b0, lat: 9});
            go(1, va[k], vb[k], vs[k], q, r, z, lat);
            e = sbq.pop_front();
            n_chk++;
            if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
                n_fail++;
                $display("FAIL signed_w8[%0d]: q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=%0d",
                         k, q, r, z, lat, e.q, e.r, e.z, e.lat);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        logic        z;
        int          lat;
        exp_t        e;
        sbq.push_back('{q: 32'hFFFF_FFFF, r: 32'h1234, z: 1'b1, lat: 1});
        go(0, 32'h1234, 32'h0, 1'b0, q, r, z, lat);
        e = sbq.pop_front();
        n_chk++;
        if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
            n_fail++;
            $display("FAIL div_zero: q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=%0d",
                     q, r, z, lat, e.q, e.r, e.z, e.lat);
        end
        sbq.push_back('{q: 32'd3, r: 32'd0, z: 1'b0, lat: 33});
        go(0, 32'd9, 32'd3, 1'b0, q, r, z, lat);
        e = sbq.pop_front();
        n_chk++;
        if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
            n_fail++;
            $display("FAIL div_zero_clear: q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=%0d",
                     q, r, z, lat, e.q, e.r, e.z, e.lat);
        end
        sbq.push_back('{q: 32'hFF, r: 32'h80, z: 1'b1, lat: 1});
        go(1, 32'h80, 32'h0, 1'b1, q, r, z, lat);
        e = sbq.pop_front();
        n_chk++;
        if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
            n_fail++;
            $display("FAIL div_zero_signed: q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=%0d",
                     q, r, z, lat, e.q, e.r, e.z, e.lat);
        end
    endtask

    task automatic test_start_ignored();
        int   lat;
        int   extra;
        exp_t e;
        sbq.push_back('{q: 32'd100, r: 32'd0, z: 1'b0, lat: 33});
        dv[0] = 32'd1000; ds[0] = 32'd10; sm[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        lat = 0;
        while (dn[0] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                st[0] = 1'b1; dv[0] = 32'd77; ds[0] = 32'd3;
            end else if (lat == 6) begin
                st[0] = 1'b0;
            end
        end
        st[0] = 1'b0;
        e = sbq.pop_front();
        n_chk++;
        if ({qo[0], ro[0], dz[0], lat} !== {e.q, e.r, e.z, e.lat}) begin
            n_fail++;
            $display("FAIL start_ignored: q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d dz=%b lat=%0d",
                     qo[0], ro[0], dz[0], lat, e.q, e.r, e.z, e.lat);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dn[0] === 1'b1 || bz[0] === 1'b1) extra++;
        end
        n_chk++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL no_queueing: %0d cycles with busy/done after op, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'd200, 32'h9C, 32'h7F};
        logic [31:0] b [3] = '{32'd7,   32'h03, 32'h80};
        logic        s [3] = '{1'b0,    1'b1,   1'b1};
        logic [31:0] q, r;
        logic        z;
        int          lat;
        exp_t        e;
        for (int k = 0; k < 3; k++) begin
            sbq.push_back(model(8, a[k], b[k], s[k]));
        end
        // Each go() after the first raises start during the previous done cycle.
        for (int k = 0; k < 3; k++) begin
            go(1, a[k], b[k], s[k], q, r, z, lat);
            e = sbq.pop_front();
            n_chk++;
            if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=%0d",
                         k, q, r, z, lat, e.q, e.r, e.z, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int          extra;
        logic [31:0] q, r;
        logic        z;
        int          lat;
        exp_t        e;
        dv[0] = 32'd123456; ds[0] = 32'd789; sm[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++;
        if ({bz[0], dn[0], dz[0], qo[0], ro[0]} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
                     bz[0], dn[0], dz[0], qo[0], ro[0]);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dn[0] === 1'b1 || bz[0] === 1'b1) extra++;
        end
        n_chk++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: %0d cycles with busy/done after reset, required 0", extra);
        end
        sbq.push_back('{q: 32'd714, r: 32'd2, z: 1'b0, lat: 33});
        go(0, 32'd5000, 32'd7, 1'b0, q, r, z, lat);
        e = sbq.pop_front();
        n_chk++;
        if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
            n_fail++;
            $display("FAIL after_reset: q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d dz=%b lat=%0d",
                     q, r, z, lat, e.q, e.r, e.z, e.lat);
        end
    endtask

    task automatic sweep(input int i, input int n_ops);
        exp_t        sb[$];
        exp_t        e;
        logic [31:0] corner [5];
        logic [31:0] m, a, b, q, r;
        logic        s, z;
        int          lat;
        m = msk(W[i]);
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = m;
        corner[3] = 32'h1 << (W[i] - 1);
        corner[4] = (32'h1 << (W[i] - 1)) - 32'h1;
        for (int n = 0; n < n_ops; n++) begin
            if (n < 50) begin
                a = corner[n % 5];
                b = corner[(n / 5) % 5];
                s = (n >= 25);
            end else begin
                a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : ($urandom() & m);
                b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : ($urandom() & m);
                s = 1'($urandom_range(0, 1));
            end
            sb.push_back(model(W[i], a, b, s));
            go(i, a, b, s, q, r, z, lat);
            e = sb.pop_front();
            n_chk++;
            if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat}) begin
                n_fail++;
                $display("FAIL sweep_w%0d: a=%h b=%h s=%b got q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=%b lat=%0d",
                         W[i], a, b, s, q, r, z, lat, e.q, e.r, e.z, e.lat);
            end
            if (b != 32'h0) begin
                n_chk++;
                if (((q * b + r) & m) !== a) begin
                    n_fail++;
                    $display("FAIL identity_w%0d: a=%h b=%h q=%h r=%h gives %h, required %h",
                             W[i], a, b, q, r, (q * b + r) & m, a);
                end
            end
        end
    endtask

    task automatic test_random_sweep();
        fork
            sweep(1, 6500);
            sweep(2, 3500);
        join
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_w8();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
